// File: rtl/bloom_pkg.sv
// Shared types and helpers for the Bloom lookup pipeline.
// The entry structs carry the default 24-bit string; the top's BYTE_W*STR_SIZE must match BLOOM_STR_W.
package bloom_pkg;

  localparam int BLOOM_BYTE_W   = 8;
  localparam int BLOOM_STR_SIZE = 3;
  localparam int BLOOM_STR_W    = BLOOM_BYTE_W * BLOOM_STR_SIZE;

  typedef enum logic {
    BLOOM_FILTER = 1'b0,
    BLOOM_TAG    = 1'b1
  } mode_t;

  typedef struct packed {
    logic [BLOOM_STR_W-1:0] data;
    mode_t                  mode;
  } lookup_entry_t;

  typedef struct packed {
    logic [BLOOM_STR_W-1:0] data;
    logic                   match;
  } result_entry_t;

  // Saturating increment of the low 'width' bits (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/bloom_result_fifo.sv
// First-word-fall-through FIFO; data visible the cycle after write, count exposed for credit accounting.
// Writes beyond capacity are refused; upstream credits guarantee that never happens.
module bloom_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_rdy,
  output logic             o_rd_vld,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_rd = i_rd_rdy && (r_count != '0);
  assign w_wr = i_wr_vld && ((r_count != CNT_W'(DEPTH)) || w_rd);

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;

endmodule

// File: rtl/bloom_lookup_pipe.sv
// Issues per-hash LUT lookups, ANDs returned bits after LUT_RD_LAT and filters/tags strings; issue-to-output >= LUT_RD_LAT+1.
// ready_o is a credit: in-flight plus buffered entries never exceed FIFO_DEPTH, so LUT data is never dropped.
module bloom_lookup_pipe
  import bloom_pkg::*;
#(
  parameter int BYTE_W      = BLOOM_BYTE_W,
  parameter int STR_SIZE    = BLOOM_STR_SIZE,
  parameter int HASHES_CNT  = 6,
  parameter int HASH_W      = 12,
  parameter int LUT_RD_LAT  = 1,
  parameter int FIFO_DEPTH  = LUT_RD_LAT + 2,
  parameter int MATCH_CNT_W = 32
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [BYTE_W*STR_SIZE-1:0]   data_i,
  input  logic [HASHES_CNT*HASH_W-1:0] hashes_i,
  input  logic                         mode_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [HASHES_CNT*HASH_W-1:0] amm_masters_lut_address_o,
  input  logic [HASHES_CNT-1:0]        amm_masters_lut_readdata_i,
  output logic [BYTE_W*STR_SIZE-1:0]   suspect_string_data_o,
  output logic                         suspect_string_match_o,
  output logic                         suspect_string_valid_o,
  input  logic                         suspect_string_ready_i,
  input  logic                         clear_cnt_i,
  output logic [MATCH_CNT_W-1:0]       lookup_cnt_o,
  output logic [MATCH_CNT_W-1:0]       match_cnt_o
);

  localparam int RES_W = $bits(result_entry_t);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + LUT_RD_LAT + 1);

  logic [LUT_RD_LAT-1:0]  r_dl_vld;
  lookup_entry_t          r_dl_ent [LUT_RD_LAT];
  logic [MATCH_CNT_W-1:0] r_lookup_cnt;
  logic [MATCH_CNT_W-1:0] r_match_cnt;

  logic                   w_issue;
  logic                   w_last_vld;
  lookup_entry_t          w_last_ent;
  logic                   w_match;
  logic                   w_fifo_wr;
  logic                   w_fifo_vld;
  logic [CNT_W-1:0]       w_fifo_cnt;
  logic [OCC_W-1:0]       w_occ;
  result_entry_t          w_res_in;
  result_entry_t          w_res_out;

  assign w_issue                   = valid_i && ready_o;
  assign amm_masters_lut_address_o = hashes_i;

  // Credits cover both in-flight lookups and buffered results.
  always_comb begin
    w_occ = OCC_W'(w_fifo_cnt);
    for (int i = 0; i < LUT_RD_LAT; i++) begin
      w_occ = w_occ + OCC_W'(r_dl_vld[i]);
    end
  end

  assign ready_o = !srst_i && (w_occ < OCC_W'(FIFO_DEPTH));

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_dl_vld <= '0;
    end else begin
      r_dl_vld[0] <= w_issue;
      for (int i = 1; i < LUT_RD_LAT; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    r_dl_ent[0] <= '{data: data_i, mode: mode_t'(mode_i)};
    for (int i = 1; i < LUT_RD_LAT; i++) begin
      r_dl_ent[i] <= r_dl_ent[i-1];
    end
  end

  assign w_last_vld = r_dl_vld[LUT_RD_LAT-1];
  assign w_last_ent = r_dl_ent[LUT_RD_LAT-1];
  assign w_match    = &amm_masters_lut_readdata_i;
  // Filtered misses are simply not written; their credit frees as the stage empties.
  assign w_fifo_wr  = w_last_vld && ((w_last_ent.mode == BLOOM_TAG) || w_match);
  assign w_res_in   = '{data: w_last_ent.data, match: w_match};

  bloom_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .i_wr_vld (w_fifo_wr),
    .i_wr_dat (w_res_in),
    .i_rd_rdy (suspect_string_ready_i),
    .o_rd_vld (w_fifo_vld),
    .o_rd_dat (w_res_out),
    .o_count  (w_fifo_cnt)
  );

  assign suspect_string_valid_o = w_fifo_vld;
  assign suspect_string_data_o  = w_res_out.data;
  assign suspect_string_match_o = w_res_out.match;

  always_ff @(posedge clk_i) begin
    if (srst_i || clear_cnt_i) begin
      r_lookup_cnt <= '0;
      r_match_cnt  <= '0;
    end else begin
      if (w_issue) begin
        r_lookup_cnt <= MATCH_CNT_W'(sat_inc(64'(r_lookup_cnt), MATCH_CNT_W));
      end
      if (w_last_vld && w_match) begin
        r_match_cnt <= MATCH_CNT_W'(sat_inc(64'(r_match_cnt), MATCH_CNT_W));
      end
    end
  end

  assign lookup_cnt_o = r_lookup_cnt;
  assign match_cnt_o  = r_match_cnt;

endmodule
